// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, oversampling constants and the
// baud divider derivation used by every baud_controller instance.
package uart_pkg;

    localparam int unsigned OVERSAMPLE = 16;
    localparam int unsigned MID_SAMPLE = 8;
    localparam int unsigned DIV_W      = 14;

    localparam int unsigned BAUD_RATE [8] = '{300, 1200, 4800, 9600,
                                              19200, 38400, 57600, 115200};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_t;

    // Rounded clk_freq / (OVERSAMPLE * baud).
    function automatic logic [DIV_W-1:0] baud_div(input int unsigned clk_freq,
                                                  input int unsigned baud);
        int unsigned q;
        q = (clk_freq + baud * (OVERSAMPLE / 2)) / (baud * OVERSAMPLE);
        return q[DIV_W-1:0];
    endfunction

endpackage

// File: rtl/baud_controller.sv
// 16x oversampling tick generator; the selected divider is reloaded only at
// wrap so a baud change never truncates a tick period.
module baud_controller
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 50_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] baud_select,
    output logic       sample_tick
);

    logic [DIV_W-1:0] div_table [8];
    logic [DIV_W-1:0] div_reg;
    logic [DIV_W-1:0] cnt_reg;

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_div
            assign div_table[gi] = baud_div(CLK_FREQ, BAUD_RATE[gi]);
        end
    endgenerate

    assign sample_tick = (cnt_reg == div_reg - 1'b1);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_reg <= '0;
            div_reg <= div_table[baud_select];
        end else if (sample_tick) begin
            cnt_reg <= '0;
            div_reg <= div_table[baud_select];
        end else begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8E1 receiver FSM with 2-flop input synchronizer and mid-bit sampling.
module uart_rx
    import uart_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_en,
    input  logic       rxd,
    input  logic       sample_tick,
    output logic       idle,
    output logic [7:0] rx_data,
    output logic       rx_ferror,
    output logic       rx_perror,
    output logic       rx_valid
);

    uart_state_t state_reg;
    logic        rx_meta_reg;
    logic        rx_sync_reg;
    logic [3:0]  tick_cnt_reg;
    logic [2:0]  bit_idx_reg;
    logic [7:0]  shift_reg;
    logic        parity_bit_reg;
    logic        last_tick;

    assign last_tick = sample_tick && (tick_cnt_reg == 4'(OVERSAMPLE - 1));
    // The RX baud counter is held clear while idle, aligning ticks to the start edge.
    assign idle      = (state_reg == ST_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta_reg <= 1'b1;
            rx_sync_reg <= 1'b1;
        end else begin
            rx_meta_reg <= rxd;
            rx_sync_reg <= rx_meta_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            tick_cnt_reg   <= '0;
            bit_idx_reg    <= '0;
            shift_reg      <= '0;
            parity_bit_reg <= 1'b0;
            rx_data        <= '0;
            rx_ferror      <= 1'b0;
            rx_perror      <= 1'b0;
            rx_valid       <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (!rx_en) begin
                state_reg <= ST_IDLE;
            end else begin
                if (state_reg != ST_IDLE && sample_tick)
                    tick_cnt_reg <= tick_cnt_reg + 1'b1;
                case (state_reg)
                    ST_IDLE: begin
                        tick_cnt_reg <= '0;
                        bit_idx_reg  <= '0;
                        if (!rx_sync_reg)
                            state_reg <= ST_START;
                    end
                    ST_START: begin
                        if (sample_tick && tick_cnt_reg == 4'(MID_SAMPLE - 1)) begin
                            tick_cnt_reg <= '0;
                            state_reg    <= rx_sync_reg ? ST_IDLE : ST_DATA;
                        end
                    end
                    ST_DATA: begin
                        if (last_tick) begin
                            shift_reg   <= {rx_sync_reg, shift_reg[7:1]};
                            bit_idx_reg <= bit_idx_reg + 1'b1;
                            if (bit_idx_reg == 3'd7)
                                state_reg <= ST_PARITY;
                        end
                    end
                    ST_PARITY: begin
                        if (last_tick) begin
                            parity_bit_reg <= rx_sync_reg;
                            state_reg      <= ST_STOP;
                        end
                    end
                    ST_STOP: begin
                        if (last_tick) begin
                            rx_data   <= shift_reg;
                            rx_perror <= (^shift_reg) != parity_bit_reg;
                            rx_ferror <= !rx_sync_reg;
                            rx_valid  <= ((^shift_reg) == parity_bit_reg) && rx_sync_reg;
                            state_reg <= ST_IDLE;
                        end
                    end
                    default: state_reg <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: rtl/uart_tx.sv
// 8E1 transmitter FSM; each frame bit lasts OVERSAMPLE sample ticks.
module uart_tx
    import uart_pkg::*;
#(
    parameter logic [7:0] TX_DATA = 8'hEA
) (
    input  logic clk,
    input  logic reset,
    input  logic tx_en,
    input  logic tx_wr,
    input  logic sample_tick,
    output logic txd,
    output logic busy
);

    uart_state_t state_reg;
    logic [3:0]  tick_cnt_reg;
    logic [2:0]  bit_idx_reg;
    logic [7:0]  shift_reg;
    logic        parity_reg;
    logic        last_tick;

    assign last_tick = sample_tick && (tick_cnt_reg == 4'(OVERSAMPLE - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            tick_cnt_reg <= '0;
            bit_idx_reg  <= '0;
            shift_reg    <= '0;
            parity_reg   <= 1'b0;
            txd          <= 1'b1;
            busy         <= 1'b0;
        end else if (!tx_en) begin
            state_reg    <= ST_IDLE;
            tick_cnt_reg <= '0;
            txd          <= 1'b1;
            busy         <= 1'b0;
        end else begin
            // The tick counter wraps by itself after OVERSAMPLE ticks.
            if (state_reg != ST_IDLE && sample_tick)
                tick_cnt_reg <= tick_cnt_reg + 1'b1;
            case (state_reg)
                ST_IDLE: begin
                    tick_cnt_reg <= '0;
                    if (tx_wr) begin
                        shift_reg   <= TX_DATA;
                        parity_reg  <= ^TX_DATA;
                        bit_idx_reg <= '0;
                        txd         <= 1'b0;
                        busy        <= 1'b1;
                        state_reg   <= ST_START;
                    end
                end
                ST_START: begin
                    if (last_tick) begin
                        txd       <= shift_reg[0];
                        shift_reg <= {1'b0, shift_reg[7:1]};
                        state_reg <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (last_tick) begin
                        bit_idx_reg <= bit_idx_reg + 1'b1;
                        if (bit_idx_reg == 3'd7) begin
                            txd       <= parity_reg;
                            state_reg <= ST_PARITY;
                        end else begin
                            txd       <= shift_reg[0];
                            shift_reg <= {1'b0, shift_reg[7:1]};
                        end
                    end
                end
                ST_PARITY: begin
                    if (last_tick) begin
                        txd       <= 1'b1;
                        state_reg <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (last_tick) begin
                        busy      <= 1'b0;
                        state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/system.sv
// UART top: free-running TX baud timing, start-edge-aligned RX baud timing,
// fixed-byte transmitter and matching receiver.
module system
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 50_000_000,
    parameter logic [7:0]  TX_DATA  = 8'hEA
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       Tx_WR,
    input  logic       Tx_EN,
    input  logic [2:0] baud_select,
    input  logic       Rx_EN,
    input  logic       RxD,
    output logic [7:0] Rx_DATA,
    output logic       Rx_FERROR,
    output logic       Rx_PERROR,
    output logic       Rx_VALID,
    output logic       TxD,
    output logic       Tx_BUSY
);

    logic tx_tick;
    logic rx_tick;
    logic rx_idle;
    logic rx_baud_rst;

    assign rx_baud_rst = reset || rx_idle;

    baud_controller #(.CLK_FREQ(CLK_FREQ)) u_tx_baud (
        .clk         (clk),
        .reset       (reset),
        .baud_select (baud_select),
        .sample_tick (tx_tick)
    );

    baud_controller #(.CLK_FREQ(CLK_FREQ)) u_rx_baud (
        .clk         (clk),
        .reset       (rx_baud_rst),
        .baud_select (baud_select),
        .sample_tick (rx_tick)
    );

    uart_tx #(.TX_DATA(TX_DATA)) u_tx (
        .clk         (clk),
        .reset       (reset),
        .tx_en       (Tx_EN),
        .tx_wr       (Tx_WR),
        .sample_tick (tx_tick),
        .txd         (TxD),
        .busy        (Tx_BUSY)
    );

    uart_rx u_rx (
        .clk         (clk),
        .reset       (reset),
        .rx_en       (Rx_EN),
        .rxd         (RxD),
        .sample_tick (rx_tick),
        .idle        (rx_idle),
        .rx_data     (Rx_DATA),
        .rx_ferror   (Rx_FERROR),
        .rx_perror   (Rx_PERROR),
        .rx_valid    (Rx_VALID)
    );

endmodule

// File: tb/tb_system.sv
// Scoreboard bench for the UART top at 115200 baud / 50 MHz.
module tb_system;

    logic       clk = 1'b0;
    logic       reset;
    logic       Tx_WR;
    logic       Tx_EN;
    logic [2:0] baud_select;
    logic       Rx_EN;
    logic       RxD;
    logic [7:0] Rx_DATA;
    logic       Rx_FERROR;
    logic       Rx_PERROR;
    logic       Rx_VALID;
    logic       TxD;
    logic       Tx_BUSY;

    system #(.CLK_FREQ(50_000_000), .TX_DATA(8'hEA)) dut (
        .clk         (clk),
        .reset       (reset),
        .Tx_WR       (Tx_WR),
        .Tx_EN       (Tx_EN),
        .baud_select (baud_select),
        .Rx_EN       (Rx_EN),
        .RxD         (RxD),
        .Rx_DATA     (Rx_DATA),
        .Rx_FERROR   (Rx_FERROR),
        .Rx_PERROR   (Rx_PERROR),
        .Rx_VALID    (Rx_VALID),
        .TxD         (TxD),
        .Tx_BUSY     (Tx_BUSY)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
    } rx_exp_t;

    rx_exp_t rx_q[$];
    bit      tx_q[$];          // 1 = full frame expected, 0 = frame will be aborted
    logic    tx_trace [0:4999];
    logic [10:0] tx_exp_bits = 11'b1_1_11101010_0;   // stop, parity, 0xEA LSB-first, start

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic check_frame(input int n);
        int s;
        int base;
        total++;
        if (n < 4726 || n > 4752) begin
            bad++;
            $display("FAIL tx_busy_len: actual=%0d required=4726..4752", n);
        end else begin
            $display("ok   tx_busy_len: %0d", n);
            s = n - 4320;
            check("tx_start_bit", {31'd0, tx_trace[0] | tx_trace[s-1]}, 32'd0);
            for (int k = 1; k < 11; k++) begin
                base = s + 432 * (k - 1);
                check($sformatf("tx_bit%0d", k),
                      {29'd0, tx_trace[base], tx_trace[base+216], tx_trace[base+431]},
                      {29'd0, {3{tx_exp_bits[k]}}});
            end
        end
    endtask

    // TX monitor: records the line for the whole busy window and checks it.
    initial begin
        bit prev = 1'b0;
        int n;
        bit full;
        forever begin
            @(negedge clk);
            if (Tx_BUSY === 1'b1 && !prev) begin
                n = 0;
                while (Tx_BUSY === 1'b1 && n < 5000) begin
                    tx_trace[n] = TxD;
                    n++;
                    @(negedge clk);
                end
                if (tx_q.size() == 0) begin
                    check("tx_unexpected_frame", 32'd1, 32'd0);
                end else begin
                    full = tx_q.pop_front();
                    if (full) begin
                        check_frame(n);
                        check("tx_idle_after", {31'd0, TxD}, 32'd1);
                    end
                end
            end
            prev = (Tx_BUSY === 1'b1);
        end
    end

    // RX monitor: a completion is a Rx_VALID pulse or a fresh nonzero error flag set.
    initial begin
        logic [1:0] prev_flags = 2'b00;
        logic [1:0] flags;
        rx_exp_t    e;
        forever begin
            @(negedge clk);
            flags = {Rx_PERROR, Rx_FERROR};
            if (Rx_VALID === 1'b1 || (flags != prev_flags && flags != 2'b00)) begin
                if (rx_q.size() == 0) begin
                    check("rx_unexpected_frame", 32'd1, 32'd0);
                end else begin
                    e = rx_q.pop_front();
                    check("rx_data", {24'd0, Rx_DATA}, {24'd0, e.data});
                    check("rx_perror", {31'd0, Rx_PERROR}, {31'd0, e.perr});
                    check("rx_ferror", {31'd0, Rx_FERROR}, {31'd0, e.ferr});
                    check("rx_valid", {31'd0, Rx_VALID}, {31'd0, !e.perr && !e.ferr});
                end
            end
            prev_flags = flags;
        end
    end

    task automatic send_rx(input logic [7:0] d, input logic par, input logic stop_v, input int stop_len);
        RxD = 1'b0;
        repeat (432) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            RxD = d[i];
            repeat (432) @(negedge clk);
        end
        RxD = par;
        repeat (432) @(negedge clk);
        RxD = stop_v;
        repeat (stop_len) @(negedge clk);
        RxD = 1'b1;
        repeat (800) @(negedge clk);
    endtask

    task automatic push_rx(input logic [7:0] d, input logic perr, input logic ferr);
        rx_exp_t e;
        e.data = d;
        e.perr = perr;
        e.ferr = ferr;
        rx_q.push_back(e);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c;
        reset       = 1'b1;
        Tx_WR       = 1'b0;
        Tx_EN       = 1'b0;
        Rx_EN       = 1'b0;
        RxD         = 1'b1;
        baud_select = 3'd7;
        repeat (100) @(negedge clk);

        check("rst_txd", {31'd0, TxD}, 32'd1);
        check("rst_busy", {31'd0, Tx_BUSY}, 32'd0);
        check("rst_rx_data", {24'd0, Rx_DATA}, 32'd0);
        check("rst_ferror", {31'd0, Rx_FERROR}, 32'd0);
        check("rst_perror", {31'd0, Rx_PERROR}, 32'd0);
        check("rst_valid", {31'd0, Rx_VALID}, 32'd0);

        reset = 1'b0;
        Tx_EN = 1'b1;
        Rx_EN = 1'b1;

        // Tick period at 115200 baud.
        c = 0;
        while (dut.tx_tick !== 1'b1 && c < 100) begin
            @(negedge clk);
            c++;
        end
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (dut.tx_tick !== 1'b1 && c < 100);
        check("tick_period", c, 32'd27);
        repeat (50) @(negedge clk);
        check("idle_txd", {31'd0, TxD}, 32'd1);
        check("idle_busy", {31'd0, Tx_BUSY}, 32'd0);

        // Full TX frame, with a write during the frame that must be ignored.
        tx_q.push_back(1'b1);
        Tx_WR = 1'b1;
        @(negedge clk);
        Tx_WR = 1'b0;
        check("wr_latency_busy", {31'd0, Tx_BUSY}, 32'd1);
        check("wr_latency_txd", {31'd0, TxD}, 32'd0);
        repeat (1000) @(negedge clk);
        Tx_WR = 1'b1;
        @(negedge clk);
        Tx_WR = 1'b0;
        c = 0;
        while (Tx_BUSY === 1'b1 && c < 6000) begin
            @(negedge clk);
            c++;
        end
        check("tx_done_in_time", {31'd0, c < 6000}, 32'd1);
        repeat (20) @(negedge clk);

        // RX frames: good, bad parity, bad stop, then glitch, then good.
        push_rx(8'h5A, 1'b0, 1'b0);
        send_rx(8'h5A, 1'b0, 1'b1, 432);
        push_rx(8'hA5, 1'b1, 1'b0);
        send_rx(8'hA5, 1'b1, 1'b1, 432);
        push_rx(8'h0F, 1'b0, 1'b1);
        send_rx(8'h0F, 1'b0, 1'b0, 300);

        RxD = 1'b0;
        repeat (100) @(negedge clk);
        RxD = 1'b1;
        repeat (600) @(negedge clk);
        check("glitch_rx_data", {24'd0, Rx_DATA}, 32'h0F);
        check("glitch_ferror", {31'd0, Rx_FERROR}, 32'd1);
        check("glitch_perror", {31'd0, Rx_PERROR}, 32'd0);
        check("rx_pending", rx_q.size(), 32'd0);

        push_rx(8'h3C, 1'b0, 1'b0);
        send_rx(8'h3C, 1'b0, 1'b1, 432);

        // Drop Tx_EN mid-frame.
        tx_q.push_back(1'b0);
        Tx_WR = 1'b1;
        @(negedge clk);
        Tx_WR = 1'b0;
        repeat (1000) @(negedge clk);
        Tx_EN = 1'b0;
        @(negedge clk);
        check("abort_txd", {31'd0, TxD}, 32'd1);
        check("abort_busy", {31'd0, Tx_BUSY}, 32'd0);
        Tx_EN = 1'b1;
        repeat (100) @(negedge clk);

        // Reset mid-receive, coinciding with a write strobe.
        RxD = 1'b0;
        repeat (432) @(negedge clk);
        RxD = 1'b1;
        repeat (432) @(negedge clk);
        RxD = 1'b0;
        repeat (200) @(negedge clk);
        reset = 1'b1;
        Tx_WR = 1'b1;
        @(negedge clk);
        check("mid_rst_rx_data", {24'd0, Rx_DATA}, 32'd0);
        check("mid_rst_ferror", {31'd0, Rx_FERROR}, 32'd0);
        check("mid_rst_perror", {31'd0, Rx_PERROR}, 32'd0);
        check("mid_rst_busy", {31'd0, Tx_BUSY}, 32'd0);
        check("mid_rst_txd", {31'd0, TxD}, 32'd1);
        reset = 1'b0;
        Tx_WR = 1'b0;
        RxD   = 1'b1;
        repeat (5000) @(negedge clk);
        check("post_rst_rx_data", {24'd0, Rx_DATA}, 32'd0);
        check("post_rst_busy", {31'd0, Tx_BUSY}, 32'd0);
        check("rx_q_empty", rx_q.size(), 32'd0);
        check("tx_q_empty", tx_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
